// File: rtl/mac_array_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_array_seq_ctrl
// Purpose  : Sequencer for an 8-MAC systolic row and its input FIFOs
//            (ROWS A-row FIFOs plus one B FIFO). Steers a byte-wide load
//            stream into the FIFOs, waits for the FIFO flags to settle, then
//            issues skewed FIFO reads and MAC clear/enable so that MAC i sees
//            A[i][k] together with B[k]. Pulses done when every accumulator
//            holds its final dot product.
// Ports    : clk, rst_n           clock, asynchronous active-low reset
//            start_i              begin a load+compute sequence (IDLE only)
//            busy_o, done_o       status; done is a one-cycle pulse
//            err_o                sticky: read issued to an empty FIFO
//            ld_valid_i/ld_data_i/ld_ready_o   load stream handshake
//            wr_data_o            shared FIFO write data (= ld_data_i)
//            wrreq_A_o/wrreq_B_o  FIFO write requests
//            wrfull_A_i/wrfull_B_i FIFO full flags
//            rdreq_A_o/rdreq_B_o  FIFO read requests
//            rdempty_A_i/rdempty_B_i FIFO empty flags
//            mac_clr_o, mac_en_o  MAC accumulator clear / chain-head enable
// Revision : 1.0  initial release
// ============================================================================
module mac_array_seq_ctrl #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_LAT   = 1,
  parameter int SYNC_WAIT  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  ld_valid_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  output logic                  ld_ready_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [ROWS-1:0]       wrreq_A_o,
  output logic                  wrreq_B_o,
  input  logic [ROWS-1:0]       wrfull_A_i,
  input  logic                  wrfull_B_i,
  output logic [ROWS-1:0]       rdreq_A_o,
  output logic                  rdreq_B_o,
  input  logic [ROWS-1:0]       rdempty_A_i,
  input  logic                  rdempty_B_i,
  output logic                  mac_clr_o,
  output logic                  mac_en_o
);

  localparam int c_FILL_N = (ROWS + 1) * COLS;
  localparam int c_T_LAST = COLS + ROWS - 2;
  // One shared counter serves fill index, wait, compute time and drain.
  localparam int c_M1     = (c_FILL_N > c_T_LAST + 1) ? c_FILL_N : c_T_LAST + 1;
  localparam int c_M2     = (c_M1 > SYNC_WAIT) ? c_M1 : SYNC_WAIT;
  localparam int c_M3     = (c_M2 > FIFO_LAT + 1) ? c_M2 : FIFO_LAT + 1;
  localparam int CW       = $clog2(c_M3 + 1);
  localparam int SW       = $clog2(ROWS + 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_FILL    = 3'd1;
  localparam logic [2:0] c_WAIT    = 3'd2;
  localparam logic [2:0] c_COMPUTE = 3'd3;
  localparam logic [2:0] c_DRAIN   = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [ROWS-1:0] rdreq_A_q, rdreq_A_d;
  logic            rdreq_B_q, rdreq_B_d;
  logic            mac_clr_q, mac_clr_d;
  logic            mac_en_q, mac_en_d;

  logic [SW-1:0]   w_sel;
  logic            w_tgt_full;
  logic            w_xfer;
  int              w_t;
  logic            w_comp;

  // Target FIFO index during FILL: A rows first, then B at index ROWS.
  assign w_sel = SW'(cnt_q / CW'(COLS));

  always_comb begin
    w_tgt_full = wrfull_B_i;
    for (int i = 0; i < ROWS; i++) begin
      if (w_sel == SW'(i)) w_tgt_full = wrfull_A_i[i];
    end
  end

  assign ld_ready_o = (state_q == c_FILL) && !w_tgt_full;
  assign w_xfer     = ld_ready_o && ld_valid_i;
  assign wr_data_o  = ld_data_i;
  assign wrreq_B_o  = w_xfer && (w_sel == SW'(ROWS));

  always_comb begin
    wrreq_A_o = '0;
    for (int i = 0; i < ROWS; i++) begin
      wrreq_A_o[i] = w_xfer && (w_sel == SW'(i));
    end
  end

  // Next-state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (|(rdreq_A_q & rdempty_A_i)) | (rdreq_B_q & rdempty_B_i);
    case (state_q)
      c_IDLE: begin
        if (start_i) begin
          state_d = c_FILL;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      c_FILL: begin
        if (w_xfer) begin
          if (cnt_q == CW'(c_FILL_N - 1)) begin
            state_d = c_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      c_WAIT: begin
        if (cnt_q == CW'(SYNC_WAIT - 1)) begin
          state_d = c_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_COMPUTE: begin
        if (cnt_q == CW'(c_T_LAST)) begin
          state_d = c_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_DRAIN: begin
        if (cnt_q == CW'(FIFO_LAT)) begin
          state_d = c_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so that they line
  // up with the state/time slot they belong to.
  assign w_t    = int'(cnt_d);
  assign w_comp = (state_d == c_COMPUTE);

  always_comb begin
    busy_d    = (state_d != c_IDLE);
    done_d    = (state_d == c_DONE);
    mac_clr_d = w_comp && (w_t == 0);
    rdreq_B_d = w_comp && (w_t < COLS);
    mac_en_d  = w_comp && (w_t >= FIFO_LAT) && (w_t <= FIFO_LAT + COLS - 1);
    rdreq_A_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      // Row i is skewed by i cycles so it meets B[k] as B ripples down the row.
      rdreq_A_d[i] = w_comp && (w_t >= i) && (w_t <= i + COLS - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdreq_A_q <= '0;
      rdreq_B_q <= 1'b0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdreq_A_q <= rdreq_A_d;
      rdreq_B_q <= rdreq_B_d;
      mac_clr_q <= mac_clr_d;
      mac_en_q  <= mac_en_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdreq_A_o = rdreq_A_q;
  assign rdreq_B_o = rdreq_B_q;
  assign mac_clr_o = mac_clr_q;
  assign mac_en_o  = mac_en_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_array_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_array_seq_ctrl
// Purpose  : Self-checking bench for mac_array_seq_ctrl with behavioural
//            FIFOs and a systolic MAC row around it.
// Revision : 1.0  initial release
// ============================================================================
module tb_mac_array_seq_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int NF   = ROWS + 1;
  localparam int NLD  = NF * COLS;
  localparam int NTBL = 22;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy, done, err;
  logic            ld_valid;
  logic [DW-1:0]   ld_data;
  logic            ld_ready;
  logic [DW-1:0]   wr_data;
  logic [ROWS-1:0] wrreq_A, wrfull_A, rdreq_A, rdempty_A;
  logic            wrreq_B, wrfull_B, rdreq_B, rdempty_B;
  logic            mac_clr, mac_en;
  logic [ROWS-1:0] frc_full_A, frc_empty_A;

  always #5 clk = ~clk;

  mac_array_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW),
                       .FIFO_LAT(1), .SYNC_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .err_o(err), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready), .wr_data_o(wr_data), .wrreq_A_o(wrreq_A),
    .wrreq_B_o(wrreq_B), .wrfull_A_i(wrfull_A), .wrfull_B_i(wrfull_B),
    .rdreq_A_o(rdreq_A), .rdreq_B_o(rdreq_B), .rdempty_A_i(rdempty_A),
    .rdempty_B_i(rdempty_B), .mac_clr_o(mac_clr), .mac_en_o(mac_en));

  // ---------------- behavioural FIFOs (non-showahead, 1-cycle latency) ------
  logic [DW-1:0] fmem [NF][COLS];
  int            fwp [NF];
  int            frp [NF];
  int            fcnt[NF];
  logic [DW-1:0] fq  [NF];
  logic [NF-1:0] f_wr, f_rd, f_full, f_empty;

  assign f_wr = {wrreq_B, wrreq_A};
  assign f_rd = {rdreq_B, rdreq_A};
  always_comb begin
    for (int f = 0; f < NF; f++) begin
      f_full[f]  = (fcnt[f] == COLS);
      f_empty[f] = (fcnt[f] == 0);
    end
  end
  assign wrfull_A  = f_full[ROWS-1:0] | frc_full_A;
  assign wrfull_B  = f_full[ROWS];
  assign rdempty_A = f_empty[ROWS-1:0] | frc_empty_A;
  assign rdempty_B = f_empty[ROWS];

  always @(posedge clk or negedge rst_n) begin : fifo_model
    int c;
    if (!rst_n) begin
      for (int f = 0; f < NF; f++) begin
        fwp[f] <= 0; frp[f] <= 0; fcnt[f] <= 0; fq[f] <= '0;
      end
    end else begin
      for (int f = 0; f < NF; f++) begin
        c = fcnt[f];
        if (f_wr[f] && fcnt[f] < COLS) begin
          fmem[f][fwp[f]] <= wr_data;
          fwp[f] <= (fwp[f] + 1) % COLS;
          c++;
        end
        if (f_rd[f] && fcnt[f] > 0) begin
          fq[f]  <= fmem[f][frp[f]];
          frp[f] <= (frp[f] + 1) % COLS;
          c--;
        end
        fcnt[f] <= c;
      end
    end
  end

  // ---------------- systolic MAC row: enable and B ripple one MAC per cycle --
  logic          en_r[ROWS];
  logic [DW-1:0] b_r [ROWS];
  int            acc [ROWS];

  always @(posedge clk or negedge rst_n) begin : mac_model
    logic e;
    logic [DW-1:0] bb;
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        en_r[i] <= 1'b0; b_r[i] <= '0; acc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (i == 0) begin e = mac_en; bb = fq[ROWS]; end
        else begin e = en_r[i-1]; bb = b_r[i-1]; end
        en_r[i] <= e;
        b_r[i]  <= bb;
        if (mac_clr) acc[i] <= 0;
        else if (e) acc[i] <= acc[i] + int'(fq[i]) * int'(bb);
      end
    end
  end

  // ---------------- checking --------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct { int tgt; logic [DW-1:0] d; } sb_t;
  sb_t sbq[$];

  // Write scoreboard: every FIFO write must match the next pushed byte.
  always @(negedge clk) begin : wr_mon
    logic [NF-1:0] w;
    int tgt;
    sb_t e;
    if (rst_n) begin
      w = {wrreq_B, wrreq_A};
      if (w != '0) begin
        tgt = -1;
        for (int f = 0; f < NF; f++) if (w == NF'(1) << f) tgt = f;
        if (sbq.size() == 0) begin
          chk("spurious_wr", 64'(w), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("wr_target", 64'(tgt), 64'(e.tgt));
          chk("wr_data", 64'(wr_data), 64'(e.d));
        end
      end
    end
  end

  // Cycle-by-cycle expectations from the first cycle after the last load.
  typedef struct {
    logic [ROWS-1:0] ra;
    logic rb, en, clr, bsy, dn, rdy;
  } vec_t;
  vec_t tbl[NTBL];

  task automatic run_seq(input bit ident, input bit stall, input bit empty5,
                         input bit start_mid, input bit do_rst);
    logic [DW-1:0] d[NLD];
    int k, pushed, stall_n, guard, e;
    logic rdy, stalling;
    for (int i = 0; i < NLD; i++) begin
      if (!ident) d[i] = DW'(i);
      else if (i < ROWS * COLS) d[i] = DW'((i / COLS) == (i % COLS));
      else d[i] = DW'(i - ROWS * COLS + 1);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared_on_start", 64'(err), 64'd0);
    @(posedge clk); #1;
    k = 0; pushed = -1; stall_n = 0; guard = 0;
    while (k < NLD && guard < 1000) begin
      guard++;
      ld_valid = 1'b1;
      ld_data  = d[k];
      if (pushed != k) begin
        sbq.push_back('{k / COLS, d[k]});
        pushed = k;
      end
      stalling = stall && (k == 2 * COLS + 3) && (stall_n < 5);
      if (stalling) stall_n++;
      frc_full_A = stalling ? ROWS'(1 << 2) : '0;
      @(negedge clk);
      rdy = ld_ready;
      if (stalling) chk("stall_no_write", 64'({ld_ready, wrreq_A, wrreq_B}), 64'd0);
      @(posedge clk);
      if (rdy) k++;
      #1;
    end
    chk("load_count", 64'(k), 64'(NLD));
    if (stall) chk("stall_cycles", 64'(stall_n), 64'd5);
    frc_full_A  = '0;
    ld_valid    = 1'b1;
    ld_data     = 8'hEE;
    frc_empty_A = empty5 ? ROWS'(1 << 5) : '0;
    for (int j = 0; j < NTBL; j++) begin
      @(negedge clk);
      chk($sformatf("seq_row%0d", j),
          64'({rdreq_A, rdreq_B, mac_en, mac_clr, busy, done, ld_ready}),
          64'({tbl[j].ra, tbl[j].rb, tbl[j].en, tbl[j].clr, tbl[j].bsy, tbl[j].dn, tbl[j].rdy}));
      start = start_mid && (j == 8);
      if (do_rst && j == 7) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({busy, done, err, ld_ready, wrreq_A, wrreq_B, rdreq_A, rdreq_B, mac_clr, mac_en}),
            64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ld_valid = 1'b0;
        frc_empty_A = '0;
        @(negedge clk);
        chk("idle_after_reset", 64'({busy, rdreq_A, rdreq_B, mac_en, ld_ready}), 64'd0);
        return;
      end
    end
    start       = 1'b0;
    ld_valid    = 1'b0;
    frc_empty_A = '0;
    chk("err_at_end", 64'(err), 64'(empty5));
    chk("all_writes_seen", 64'(sbq.size()), 64'd0);
    for (int i = 0; i < ROWS; i++) begin
      e = 0;
      for (int c = 0; c < COLS; c++) e += int'(d[i * COLS + c]) * int'(d[ROWS * COLS + c]);
      chk($sformatf("mac%0d_result", i), 64'(acc[i]), 64'(e));
    end
  endtask

  initial begin
    for (int j = 0; j < NTBL; j++) tbl[j] = '{8'h00, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{8'h01, 1, 0, 1, 1, 0, 0};
    tbl[4]  = '{8'h03, 1, 1, 0, 1, 0, 0};
    tbl[5]  = '{8'h07, 1, 1, 0, 1, 0, 0};
    tbl[6]  = '{8'h0F, 1, 1, 0, 1, 0, 0};
    tbl[7]  = '{8'h1F, 1, 1, 0, 1, 0, 0};
    tbl[8]  = '{8'h3F, 1, 1, 0, 1, 0, 0};
    tbl[9]  = '{8'h7F, 1, 1, 0, 1, 0, 0};
    tbl[10] = '{8'hFF, 1, 1, 0, 1, 0, 0};
    tbl[11] = '{8'hFE, 0, 1, 0, 1, 0, 0};
    tbl[12] = '{8'hFC, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{8'hF8, 0, 0, 0, 1, 0, 0};
    tbl[14] = '{8'hF0, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{8'hE0, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{8'hC0, 0, 0, 0, 1, 0, 0};
    tbl[17] = '{8'h80, 0, 0, 0, 1, 0, 0};
    tbl[20] = '{8'h00, 0, 0, 0, 1, 1, 0};
    tbl[21] = '{8'h00, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    frc_full_A = '0; frc_empty_A = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        64'({busy, done, err, ld_ready, wrreq_A, wrreq_B, rdreq_A, rdreq_B, mac_clr, mac_en}),
        64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ld_ready", 64'({ld_ready, busy}), 64'd0);

    run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // ramp data, clean stream
    run_seq(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);   // full stall + ignored start
    run_seq(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // empty flag -> sticky err
    run_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // identity A, B = 1..8
    run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // reset in mid-compute
    sbq.delete();
    run_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // clean run after abort

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
